cur_blk_fetch: RTL and testbench
================================

Name: cur_blk_fetch

Overview:
- Initiator for the current-frame memory port. On `start`, it fetches one BLK_SIZE x BLK_SIZE block of 8-bit luma pixels, 32 bits per read.
- Fetched words go into an on-chip block buffer. The ME core reads the buffer through a registered read port.
- Sits between the ME core's block scheduler and the current-frame memory model/controller.

Parameters:
- FRAME_W, 1920: frame width in pixels (bytes per line); must be a multiple of 4.
- FRAME_H, 1080: frame height in lines.
- BLK_SIZE, 16: block edge in pixels; must be a multiple of 4.
- BASE_ADDR, 0: byte address of pixel (0,0) of the current frame.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to fetch block (blk_x, blk_y); sampled only in IDLE.
- blk_x  in  16  block column index, in block units.
- blk_y  in  16  block row index, in block units.
- busy  out  1  high while a fetch is in progress.
- done  out  1  one-cycle pulse when a fetch completes or is rejected.
- err  out  1  valid with done: coordinates were out of range and nothing was fetched.
- mem_en  out  1  read enable to current-frame memory.
- mem_addr  out  32  byte address to current-frame memory.
- mem_data  in  32  read data; combinational from mem_en/mem_addr; byte at mem_addr is on [7:0].
- rd_addr  in  log2(BLK_SIZE*BLK_SIZE/4)  buffer word index, = row*(BLK_SIZE/4)+col.
- rd_data  out  32  buffer word; registered, 1-cycle latency.

Behaviour:
- Reset values: busy=0, done=0, err=0, mem_en=0, mem_addr=0, rd_data=0, FSM=IDLE. Buffer contents are not cleared.
- FSM states: IDLE, FETCH, FIN.
- IDLE, start=1, coordinates in range (blk_x < FRAME_W/BLK_SIZE and blk_y < FRAME_H/BLK_SIZE):
  - -> FETCH.
  - Row/column counters are cleared.
  - busy=1, mem_en=1, mem_addr = word 0 address, all from the next cycle.
- IDLE, start=1, coordinates out of range: -> FIN with err=1. No memory access.
- Word address: BASE_ADDR + (blk_y*BLK_SIZE + row)*FRAME_W + blk_x*BLK_SIZE + 4*col, with row 0..BLK_SIZE-1 and col 0..BLK_SIZE/4-1.
  - Column counter is innermost.
  - Arithmetic is 32-bit unsigned; no wrap is checked beyond the range test.
- FETCH, each cycle:
  - mem_data is captured into buffer[row*(BLK_SIZE/4)+col] at the clock edge ending the cycle in which mem_en=1.
  - The counters then advance, so throughput is one word per cycle.
- After the last word (row=BLK_SIZE-1, col=BLK_SIZE/4-1) is captured: mem_en=0, mem_addr holds its last value, -> FIN.
- FIN: done=1 and busy=0 for exactly one cycle, then -> IDLE. err stays 0 unless the request was rejected.
- Latency: with BLK_SIZE=16, start sampled at edge 0; words captured at edges 1..64; done high in the cycle after edge 64.
- start while busy or in FIN is ignored; it is not queued.
- blk_x/blk_y are sampled only together with the accepted start, so later changes have no effect.
- rd_data <= buffer[rd_addr] every cycle, regardless of state. Reads during FETCH of the same bank return partially updated contents and are not checked.
- rst during FETCH:
  - Immediate return to IDLE; mem_en=0 next cycle.
  - No done pulse.
  - Buffer contents are undefined.

Optional Feature:
- Macro: CUR_FETCH_PINGPONG_EN.
- Defined:
  - Two buffer banks; a bank select register resets to 0.
  - Fetches write bank `sel`; the read port reads bank `~sel`.
  - `sel` toggles in the FIN cycle of a successful fetch, not after an err fetch, so the just-fetched block becomes readable the cycle after done.
  - The ME core may read block N while block N+1 is fetched.
- Undefined: single bank; fetch and read share it.

Test Plan:
- Reset then idle: rst for 2 cycles -> busy=0, done=0, mem_en=0, rd_data=0; start held 0 -> no mem_en for 100 cycles.
- Block (2,1), FRAME_W=1920, BLK_SIZE=16:
  - start -> mem_en high for exactly 64 consecutive cycles.
  - First mem_addr=30752, second 30756, fifth (row 1, col 0) 32672, last 59564.
  - done one cycle after the last word; err=0.
- Data check:
  - Memory model filled with byte = address mod 251; fetch block (0,0).
  - Then rd_addr=5 -> rd_data bytes [7:0]..[31:24] = mem[1924], mem[1925], mem[1926], mem[1927], one cycle after rd_addr is applied.
- Out of range: start with blk_x=120 (1920/16) -> no mem_en; done=1 with err=1 two cycles after start; busy never 1.
- Ignored start: a second start 10 cycles into a fetch -> exactly 64 mem_en cycles total and a single done pulse.
  - Then rst at word 30 of a new fetch -> mem_en=0 the next cycle; no done.
- With CUR_FETCH_PINGPONG_EN:
  - Fetch (0,0), then (1,0); read rd_addr=0 during the second fetch -> returns block (0,0) word 0, mem[0..3].
  - After the second done -> returns mem[16..19].

Source files
------------

// File: rtl/cur_blk_fetch_if.sv
// Bus bundle for cur_blk_fetch: scheduler request/response, current-frame
// memory read port and block-buffer read port.
// master: the fetch block's view.  slave: the surrounding environment's view.
interface cur_blk_fetch_if #(
    parameter int RD_AW = 6
);
    logic             start;
    logic [15:0]      blk_x;
    logic [15:0]      blk_y;
    logic             busy;
    logic             done;
    logic             err;
    logic             mem_en;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_data;
    logic [RD_AW-1:0] rd_addr;
    logic [31:0]      rd_data;

    modport master (
        input  start, blk_x, blk_y, mem_data, rd_addr,
        output busy, done, err, mem_en, mem_addr, rd_data
    );

    modport slave (
        output start, blk_x, blk_y, mem_data, rd_addr,
        input  busy, done, err, mem_en, mem_addr, rd_data
    );
endinterface

// File: rtl/cur_blk_fetch.sv
// cur_blk_fetch: fetches one BLK_SIZE x BLK_SIZE luma block from the
// current-frame memory (one 32-bit word per cycle) into an on-chip block
// buffer that the ME core reads through a registered read port.
// Optional feature macro: CUR_FETCH_PINGPONG_EN -- two buffer banks, fetch
// writes bank sel while the read port reads bank ~sel; sel flips after each
// successful fetch.
module cur_blk_fetch #(
    parameter int          FRAME_W   = 1920,
    parameter int          FRAME_H   = 1080,
    parameter int          BLK_SIZE  = 16,
    parameter logic [31:0] BASE_ADDR = 32'd0
) (
    input  logic           clk,
    input  logic           rst,
    cur_blk_fetch_if.master bus
);

    localparam int WPR    = BLK_SIZE / 4;
    localparam int NWORDS = (BLK_SIZE * BLK_SIZE) / 4;
    localparam int RD_AW  = $clog2(NWORDS);
    localparam int COL_W  = (WPR > 1) ? $clog2(WPR) : 1;

    localparam logic [31:0]      BLK_COLS      = 32'(FRAME_W / BLK_SIZE);
    localparam logic [31:0]      BLK_ROWS      = 32'(FRAME_H / BLK_SIZE);
    localparam logic [31:0]      BLK_ROW_BYTES = 32'(BLK_SIZE * FRAME_W);
    localparam logic [31:0]      BLK_BYTES     = 32'(BLK_SIZE);
    localparam logic [31:0]      LINE_BYTES    = 32'(FRAME_W);
    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(WPR - 1);
    localparam logic [RD_AW-1:0] WIDX_LAST     = RD_AW'(NWORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FIN   = 2'd2
    } state_e;

    state_e           state_q,    state_d;
    logic [COL_W-1:0] col_q,      col_d;
    logic [RD_AW-1:0] widx_q,     widx_d;
    logic [31:0]      row_base_q, row_base_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic             mem_en_q,   mem_en_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             err_q,      err_d;
    logic [31:0]      rd_data_q;

    logic             in_range_s;
    logic [31:0]      start_addr_s;

`ifdef CUR_FETCH_PINGPONG_EN
    logic             sel_q, sel_d;
    logic [RD_AW:0]   wr_ptr_s;
    logic [RD_AW:0]   rd_ptr_s;
    logic [31:0]      buf_mem [0:2*NWORDS-1];
`else
    logic [RD_AW-1:0] wr_ptr_s;
    logic [RD_AW-1:0] rd_ptr_s;
    logic [31:0]      buf_mem [0:NWORDS-1];
`endif

    // Request decode: range test and address of word 0 of the requested block.
    always_comb begin
        in_range_s   = ({16'd0, bus.blk_x} < BLK_COLS) && ({16'd0, bus.blk_y} < BLK_ROWS);
        start_addr_s = BASE_ADDR
                     + ({16'd0, bus.blk_y} * BLK_ROW_BYTES)
                     + ({16'd0, bus.blk_x} * BLK_BYTES);
    end

    // Buffer pointers; with two banks the write and read sides use opposite banks.
    always_comb begin
`ifdef CUR_FETCH_PINGPONG_EN
        wr_ptr_s = {sel_q, widx_q};
        rd_ptr_s = {~sel_q, bus.rd_addr};
`else
        wr_ptr_s = widx_q;
        rd_ptr_s = bus.rd_addr;
`endif
    end

    // FSM next-state logic: addresses advance incrementally (+4 per column,
    // +FRAME_W per row) so no multiplier sits in the per-word path.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        widx_d     = widx_q;
        row_base_d = row_base_q;
        mem_addr_d = mem_addr_q;
        mem_en_d   = mem_en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
`ifdef CUR_FETCH_PINGPONG_EN
        sel_d      = sel_q;
`endif
        case (state_q)
            ST_IDLE: begin
                err_d = 1'b0;
                if (bus.start) begin
                    if (in_range_s) begin
                        state_d    = ST_FETCH;
                        col_d      = '0;
                        widx_d     = '0;
                        row_base_d = start_addr_s;
                        mem_addr_d = start_addr_s;
                        mem_en_d   = 1'b1;
                        busy_d     = 1'b1;
                    end else begin
                        // Rejected request: report through FIN without touching memory.
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (widx_q == WIDX_LAST) begin
                    // Last word captured at this edge; hold the final address.
                    state_d  = ST_FIN;
                    mem_en_d = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    widx_d = widx_q + {{(RD_AW-1){1'b0}}, 1'b1};
                    if (col_q == COL_LAST) begin
                        col_d      = '0;
                        row_base_d = row_base_q + LINE_BYTES;
                        mem_addr_d = row_base_q + LINE_BYTES;
                    end else begin
                        col_d      = col_q + {{(COL_W-1){1'b0}}, 1'b1};
                        mem_addr_d = mem_addr_q + 32'd4;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
`ifdef CUR_FETCH_PINGPONG_EN
                // Publish the freshly fetched bank only after a real fetch.
                if (!err_q) begin
                    sel_d = ~sel_q;
                end else begin
                    sel_d = sel_q;
                end
`endif
            end
            default: begin
                state_d  = ST_IDLE;
                mem_en_d = 1'b0;
                busy_d   = 1'b0;
                err_d    = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            widx_q     <= '0;
            row_base_q <= 32'd0;
            mem_addr_q <= 32'd0;
            mem_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef CUR_FETCH_PINGPONG_EN
            sel_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            widx_q     <= widx_d;
            row_base_q <= row_base_d;
            mem_addr_q <= mem_addr_d;
            mem_en_q   <= mem_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef CUR_FETCH_PINGPONG_EN
            sel_q      <= sel_d;
`endif
        end
    end

    // Capture the returning word into the buffer; contents are never cleared.
    always_ff @(posedge clk) begin
        if (!rst && mem_en_q) begin
            buf_mem[wr_ptr_s] <= bus.mem_data;
        end
    end

    // Registered buffer read port, one cycle latency, active in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= 32'd0;
        end else begin
            rd_data_q <= buf_mem[rd_ptr_s];
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.mem_en   = mem_en_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_cur_blk_fetch.sv
// Self-checking bench for cur_blk_fetch (FRAME_W=1920, FRAME_H=1080, BLK_SIZE=16).
module tb_cur_blk_fetch;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cur_blk_fetch_if #(.RD_AW(6)) bus ();

    cur_blk_fetch #(
        .FRAME_W   (1920),
        .FRAME_H   (1080),
        .BLK_SIZE  (16),
        .BASE_ADDR (32'd0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mb(input logic [31:0] a);
        return 8'(a % 32'd251);
    endfunction

    function automatic logic [31:0] mword(input logic [31:0] a);
        return {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
    endfunction

    // Independent address model: the closed-form word address.
    function automatic logic [31:0] exp_addr(input int x, input int y, input int k);
        int row;
        int col;
        row = k / 4;
        col = k % 4;
        return 32'((y * 16 + row) * 1920 + x * 16 + 4 * col);
    endfunction

    // Current-frame memory model: combinational read.
    assign bus.mem_data = mword(bus.mem_addr);

    typedef struct {
        int x;
        int y;
        bit exp_err;
        int second_at;
    } vec_t;

    typedef struct {
        int          a;
        logic [31:0] exp;
    } rd_t;

    vec_t        vecs [6];
    rd_t         rds  [5];
    logic [31:0] sb_q [$];
    logic [31:0] seen [64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          en_cnt;
        int          done_cnt;
        int          done_s;
        int          first_en;
        int          busy_seen;
        logic        err_at_done;
        logic [31:0] e;
        sb_q.delete();
        en_cnt = 0; done_cnt = 0; done_s = -1; first_en = -1; busy_seen = 0; err_at_done = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.blk_x = 16'(v.x);
        bus.blk_y = 16'(v.y);
        if (!v.exp_err) begin
            for (int k = 0; k < 64; k++) sb_q.push_back(exp_addr(v.x, v.y, k));
        end
        for (int s = 0; s < 80; s++) begin
            @(negedge clk);
            if (bus.mem_en) begin
                if (first_en < 0) first_en = s;
                if (en_cnt < 64) seen[en_cnt] = bus.mem_addr;
                en_cnt++;
                if (sb_q.size() == 0) begin
                    chk("mem_en_extra", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("mem_addr", bus.mem_addr, e);
                end
            end
            if (bus.busy) busy_seen = 1;
            if (bus.done) begin
                done_cnt++;
                done_s      = s;
                err_at_done = bus.err;
            end
            if (s == v.second_at) begin
                bus.start = 1'b1;
                bus.blk_x = 16'd7;
                bus.blk_y = 16'd3;
            end else begin
                bus.start = 1'b0;
            end
        end
        chk("mem_en_cycles", 32'(en_cnt), v.exp_err ? 32'd0 : 32'd64);
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("err_with_done", {31'd0, err_at_done}, {31'd0, v.exp_err});
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        if (v.exp_err) begin
            chk("busy_seen", 32'(busy_seen), 32'd0);
            chk("err_done_timing", {31'd0, (done_s >= 0 && done_s <= 1)}, 32'd1);
        end else begin
            chk("first_mem_en", 32'(first_en), 32'd0);
            chk("done_timing", 32'(done_s), 32'd64);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_en;
        int cnt_done;
        int row;
        int col;
        int found;

        checks = 0;
        errors = 0;

        vecs[0] = '{x: 2,   y: 1,  exp_err: 1'b0, second_at: -1};
        vecs[1] = '{x: 119, y: 66, exp_err: 1'b0, second_at: -1};
        vecs[2] = '{x: 120, y: 0,  exp_err: 1'b1, second_at: -1};
        vecs[3] = '{x: 0,   y: 67, exp_err: 1'b1, second_at: -1};
        vecs[4] = '{x: 3,   y: 2,  exp_err: 1'b0, second_at: 10};
        vecs[5] = '{x: 0,   y: 0,  exp_err: 1'b0, second_at: -1};

        for (int i = 0; i < 5; i++) begin
            rds[i].a = (i == 0) ? 5 : (i == 1) ? 0 : (i == 2) ? 3 : (i == 3) ? 63 : 4;
            row = rds[i].a / 4;
            col = rds[i].a % 4;
            rds[i].exp = mword(32'(row * 1920 + 4 * col));
        end

        // Reset then idle.
        rst = 1'b1;
        bus.start = 1'b0;
        bus.blk_x = 16'd0;
        bus.blk_y = 16'd0;
        bus.rd_addr = 6'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_rd_data", bus.rd_data, 32'd0);
        rst = 1'b0;
        cnt_en = 0;
        cnt_done = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.mem_en) cnt_en++;
            if (bus.done) cnt_done++;
        end
        chk("idle_mem_en", 32'(cnt_en), 32'd0);
        chk("idle_done", 32'(cnt_done), 32'd0);

        // Table of fetch requests.
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
            if (vecs[i].x == 2 && vecs[i].y == 1) begin
                chk("addr_first", seen[0], 32'd30752);
                chk("addr_second", seen[1], 32'd30756);
                chk("addr_fifth", seen[4], 32'd32672);
                chk("addr_last", seen[63], 32'd59564);
            end
        end

        // Buffer read-back of block (0,0), one cycle latency.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.rd_addr = 6'(rds[i].a);
            @(negedge clk);
            chk("rd_data", bus.rd_data, rds[i].exp);
            if (rds[i].a == 5) chk("rd_data_w5", bus.rd_data, 32'hAAA9A8A7);
        end

`ifdef CUR_FETCH_PINGPONG_EN
        // Read block (0,0) while block (1,0) is fetched, then see (1,0).
        @(negedge clk);
        bus.start = 1'b1;
        bus.blk_x = 16'd1;
        bus.blk_y = 16'd0;
        bus.rd_addr = 6'd0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pp_read_old", bus.rd_data, 32'h03020100);
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            @(negedge clk);
            if (bus.done) found = 1;
        end
        chk("pp_done_seen", 32'(found), 32'd1);
        repeat (2) @(negedge clk);
        chk("pp_read_new", bus.rd_data, 32'h13121110);
`endif

        // Reset in the middle of a fetch.
        @(negedge clk);
        bus.start = 1'b1;
        bus.blk_x = 16'd4;
        bus.blk_y = 16'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (30) @(negedge clk);
        chk("mid_mem_en", {31'd0, bus.mem_en}, 32'd1);
        chk("mid_addr", bus.mem_addr, exp_addr(4, 4, 30));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_mem_en", {31'd0, bus.mem_en}, 32'd0);
        chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        cnt_en = 0;
        cnt_done = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (bus.mem_en) cnt_en++;
            if (bus.done) cnt_done++;
        end
        chk("post_rst_mem_en", 32'(cnt_en), 32'd0);
        chk("post_rst_done", 32'(cnt_done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
